// File: rtl/placar_pkg.sv
// Shared scoreboard definitions: FSM state encoding and datapath widths.
package placar_pkg;

    localparam int CRONO_W  = 5;
    localparam int PLACAR_W = 7;

    typedef enum logic [1:0] {
        PRONTO   = 2'd0,
        CORRENDO = 2'd1,
        PAUSADO  = 2'd2,
        ESGOTADO = 2'd3
    } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// Free-running modulo-N counter with a one-cycle tick on its last count.
module divisor_tick #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/cronometro_posse_ctrl.sv
// Shot-clock countdown FSM plus the 60 Hz and 2 s select clocks
// that drive the scoreboard display multiplexer.
module cronometro_posse_ctrl
    import placar_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TEMPO_INICIAL = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               pausar,
    input  logic               reiniciar,
    output logic [CRONO_W-1:0] cronometro,
    output logic               clock60hz,
    output logic               clock2segs,
    output logic               esgotado,
    output logic               estouro
);

    if (TEMPO_INICIAL < 1 || TEMPO_INICIAL > 31) begin : g_tempo_invalido
        $error("TEMPO_INICIAL out of range 1..31");
    end

    if (CLK_HZ < 120) begin : g_clk_invalido
        $error("CLK_HZ must be at least 120");
    end

    localparam int SEG_W = $clog2(CLK_HZ);
    localparam logic [SEG_W-1:0]   SEG_LAST = SEG_W'(CLK_HZ - 1);
    localparam logic [CRONO_W-1:0] RELOAD   = CRONO_W'(TEMPO_INICIAL);

    estado_t          estado;
    logic [SEG_W-1:0] seg_cnt;
    logic [2:0]       btn_q;
    logic             rise_i;
    logic             rise_p;
    logic             rise_r;
    logic             tick60;
    logic             tick1s;
    logic             fase2s;

    divisor_tick #(.N(CLK_HZ / 120)) u_div60 (
        .clock (clock),
        .reset (reset),
        .tick  (tick60)
    );

    divisor_tick #(.N(CLK_HZ)) u_div1s (
        .clock (clock),
        .reset (reset),
        .tick  (tick1s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= {reiniciar, pausar, iniciar};
        end
    end

    assign rise_i = iniciar   & ~btn_q[0];
    assign rise_p = pausar    & ~btn_q[1];
    assign rise_r = reiniciar & ~btn_q[2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clock60hz <= 1'b0;
        end else if (tick60) begin
            clock60hz <= ~clock60hz;
        end
    end

    // Output flips on every second 1 s tick, giving a 4 s period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fase2s     <= 1'b0;
            clock2segs <= 1'b0;
        end else if (tick1s) begin
            fase2s <= ~fase2s;
            if (fase2s) begin
                clock2segs <= ~clock2segs;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= PRONTO;
            cronometro <= RELOAD;
            seg_cnt    <= '0;
            esgotado   <= 1'b0;
            estouro    <= 1'b0;
        end else begin
            estouro <= 1'b0;
            if (rise_r) begin
                estado     <= PRONTO;
                cronometro <= RELOAD;
                seg_cnt    <= '0;
                esgotado   <= 1'b0;
            end else begin
                unique case (estado)
                    PRONTO: begin
                        if (!rise_p && rise_i) begin
                            estado <= CORRENDO;
                        end
                    end
                    // A pause request holds the prescaler and skips the tick.
                    CORRENDO: begin
                        if (rise_p) begin
                            estado <= PAUSADO;
                        end else if (seg_cnt == SEG_LAST) begin
                            seg_cnt <= '0;
                            if (cronometro <= CRONO_W'(1)) begin
                                cronometro <= '0;
                                estouro    <= 1'b1;
                                esgotado   <= 1'b1;
                                estado     <= ESGOTADO;
                            end else begin
                                cronometro <= cronometro - 1'b1;
                            end
                        end else begin
                            seg_cnt <= seg_cnt + 1'b1;
                        end
                    end
                    PAUSADO: begin
                        if (!rise_p && rise_i) begin
                            estado <= CORRENDO;
                        end
                    end
                    ESGOTADO: begin
                        cronometro <= '0;
                        esgotado   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
